// File: rtl/vend_ctrl_gen_if.sv
// Front-panel and display bundle of the vending controller.
// The bench drives through the master modport; the controller uses the slave modport.
interface vend_ctrl_gen_if #(
    parameter int N_PROD = 4,
    parameter int CW     = 8
);
    logic                 tick;
    logic [2:0]           coin;
    logic                 cancel;
    logic [N_PROD-1:0]    sel;
    logic [N_PROD*CW-1:0] prices;
    logic [CW-1:0]        credit;
    logic [CW-1:0]        price;
    logic [N_PROD-1:0]    vend;
    logic [2:0]           chg_coin;
    logic                 reject;
    logic                 busy;

    modport master (
        output tick, coin, cancel, sel, prices,
        input  credit, price, vend, chg_coin, reject, busy
    );
    modport slave (
        input  tick, coin, cancel, sel, prices,
        output credit, price, vend, chg_coin, reject, busy
    );
endinterface

// File: rtl/vend_ctrl_gen.sv
// Vending controller: coin credit accumulation, runtime-priced vend and tick-paced coin change.
//  state    | meaning
//  S_IDLE   | no credit held
//  S_CREDIT | credit > 0, waiting for an affordable selection or cancel
//  S_VEND   | one clk: vend pulse, snapshot price subtracted
//  S_CHANGE | one coin returned per tick until credit is 0
module vend_ctrl_gen #(
    parameter int N_PROD     = 4,
    parameter int CW         = 8,
    parameter int MAX_CREDIT = 35,
    parameter int COIN0      = 5,
    parameter int COIN1      = 10,
    parameter int COIN2      = 25
) (
    input  logic           clk,
    input  logic           clr_n,
    vend_ctrl_gen_if.slave bus
);
    localparam int IW = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam logic [CW:0] C0   = (CW+1)'(COIN0);
    localparam logic [CW:0] C1   = (CW+1)'(COIN1);
    localparam logic [CW:0] C2   = (CW+1)'(COIN2);
    localparam logic [CW:0] MAXC = (CW+1)'(MAX_CREDIT);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;
    state_t state_q, state_d;

    logic [2:0]    coin_s1, coin_s2, coin_d;
    logic          cancel_s1, cancel_s2, cancel_d;
    logic [2:0]    coin_edge;
    logic          cancel_edge;
    logic          coin_any;
    logic [CW:0]   coin_val;
    logic [CW:0]   coin_sum;
    logic [CW-1:0] sel_price;
    logic [IW-1:0] sel_idx;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] sale_price_q, sale_price_d;
    logic [IW-1:0] sale_idx_q, sale_idx_d;
    logic [2:0]    chg_q, chg_d;
    logic          reject_q, reject_d;
    logic [N_PROD-1:0] vend_oh;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            coin_s1   <= '0;
            coin_s2   <= '0;
            coin_d    <= '0;
            cancel_s1 <= 1'b0;
            cancel_s2 <= 1'b0;
            cancel_d  <= 1'b0;
        end else begin
            coin_s1   <= bus.coin;
            coin_s2   <= coin_s1;
            coin_d    <= coin_s2;
            cancel_s1 <= bus.cancel;
            cancel_s2 <= cancel_s1;
            cancel_d  <= cancel_s2;
        end
    end

    assign coin_edge   = coin_s2 & ~coin_d;
    assign cancel_edge = cancel_s2 & ~cancel_d;
    assign coin_any    = |coin_edge;

    // Lowest coin index wins when edges coincide; the rest are dropped silently.
    always_comb begin
        coin_val = '0;
        if (coin_edge[0])      coin_val = C0;
        else if (coin_edge[1]) coin_val = C1;
        else if (coin_edge[2]) coin_val = C2;
    end

    assign coin_sum = {1'b0, credit_q} + coin_val;

    always_comb begin
        sel_price = '0;
        sel_idx   = '0;
        for (int i = N_PROD-1; i >= 0; i--) begin
            if (bus.sel[i]) begin
                sel_price = bus.prices[i*CW +: CW];
                sel_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= S_IDLE;
            credit_q     <= '0;
            sale_price_q <= '0;
            sale_idx_q   <= '0;
            chg_q        <= '0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            sale_price_q <= sale_price_d;
            sale_idx_q   <= sale_idx_d;
            chg_q        <= chg_d;
            reject_q     <= reject_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        sale_price_d = sale_price_q;
        sale_idx_d   = sale_idx_q;
        chg_d        = '0;
        reject_d     = 1'b0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (coin_any) begin
                    if (coin_sum <= MAXC) begin
                        credit_d = coin_sum[CW-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                // A coin landing in the purchase clk is kept; VEND subtracts from the new total.
                if (state_q == S_CREDIT) begin
                    if (sel_price != '0 && credit_q >= sel_price) begin
                        state_d      = S_VEND;
                        sale_price_d = sel_price;
                        sale_idx_d   = sel_idx;
                    end else if (cancel_edge) begin
                        state_d = S_CHANGE;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_any;
                credit_d = credit_q - sale_price_q;
                state_d  = (credit_q == sale_price_q) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                reject_d = coin_any;
                if (bus.tick) begin
                    if ({1'b0, credit_q} >= C2) begin
                        chg_d    = 3'b100;
                        credit_d = credit_q - C2[CW-1:0];
                    end else if ({1'b0, credit_q} >= C1) begin
                        chg_d    = 3'b010;
                        credit_d = credit_q - C1[CW-1:0];
                    end else if ({1'b0, credit_q} >= C0) begin
                        chg_d    = 3'b001;
                        credit_d = credit_q - C0[CW-1:0];
                    end else begin
                        credit_d = '0;
                    end
                    if (credit_d == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vend_oh = '0;
        if (state_q == S_VEND) vend_oh[sale_idx_q] = 1'b1;
    end

    assign bus.credit   = credit_q;
    assign bus.price    = sel_price;
    assign bus.vend     = vend_oh;
    assign bus.chg_coin = chg_q;
    assign bus.reject   = reject_q;
    assign bus.busy     = (state_q == S_VEND) || (state_q == S_CHANGE);
endmodule

// File: tb/tb_vend_ctrl_gen.sv
// Bench for vend_ctrl_gen: vector table, corner sequences and a random run against a credit-level model.
module tb_vend_ctrl_gen;
    localparam int NP   = 4;
    localparam int CW   = 8;
    localparam int MAXC = 35;

    typedef struct {
        int         act;     // 0..2 coin k, 3 cancel, 4 select only
        logic [3:0] sel;
        int         credit;
        int         rej;
        logic [3:0] vmask;
        int         chg;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    vend_ctrl_gen_if #(.N_PROD(NP), .CW(CW)) bus ();

    vend_ctrl_gen #(.N_PROD(NP), .CW(CW), .MAX_CREDIT(MAXC),
                    .COIN0(5), .COIN1(10), .COIN2(25)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int vend_cnt[NP];
    int chg_cnt[3];
    int rej_cnt;
    int chg_log[$];
    int chg_cyc[$];
    int mcyc = 0;
    int tcyc = 0;
    bit tick_en = 1'b1;
    int mprice[NP];
    vec_t tbl[$];

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            tcyc++;
            bus.tick = tick_en && (tcyc % 4 == 0);
        end
    end

    always @(negedge clk) begin
        mcyc++;
        if (clr_n) begin
            for (int i = 0; i < NP; i++) if (bus.vend[i]) vend_cnt[i]++;
            for (int k = 0; k < 3; k++) if (bus.chg_coin[k]) begin
                chg_cnt[k]++;
                chg_log.push_back(k);
                chg_cyc.push_back(mcyc);
            end
            if (bus.reject) rej_cnt++;
        end
    end

    function automatic int coin_value(int k);
        return (k == 0) ? 5 : (k == 1) ? 10 : 25;
    endfunction

    function automatic int chg_value();
        return 5*chg_cnt[0] + 10*chg_cnt[1] + 25*chg_cnt[2];
    endfunction

    function automatic logic [3:0] vend_mask();
        logic [3:0] m;
        for (int i = 0; i < NP; i++) m[i] = (vend_cnt[i] != 0);
        return m;
    endfunction

    function automatic int model_price(logic [3:0] s);
        for (int i = 0; i < NP; i++) if (s[i]) return mprice[i];
        return 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NP; i++) vend_cnt[i] = 0;
        for (int k = 0; k < 3; k++) chg_cnt[k] = 0;
        rej_cnt = 0;
        chg_log.delete();
        chg_cyc.delete();
    endtask

    task automatic load_prices();
        for (int i = 0; i < NP; i++) bus.prices[i*CW +: CW] = 8'(mprice[i]);
    endtask

    task automatic press(logic [2:0] c, logic can);
        @(negedge clk);
        bus.coin = c;
        bus.cancel = can;
        repeat (3) @(negedge clk);
        bus.coin = 3'b000;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_coin(int k);
        logic [2:0] c;
        c = 3'b000;
        c[k] = 1'b1;
        press(c, 1'b0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && bus.busy; n++) @(negedge clk);
        check("idle_timeout", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_table();
        foreach (tbl[r]) begin
            clear_counts();
            bus.sel = tbl[r].sel;
            if (tbl[r].act <= 2)      press_coin(tbl[r].act);
            else if (tbl[r].act == 3) press(3'b000, 1'b1);
            else                      repeat (4) @(negedge clk);
            wait_idle();
            check($sformatf("row%0d_credit", r), int'(bus.credit), tbl[r].credit);
            check($sformatf("row%0d_reject", r), rej_cnt, tbl[r].rej);
            check($sformatf("row%0d_vend", r), int'(vend_mask()), int'(tbl[r].vmask));
            check($sformatf("row%0d_change", r), chg_value(), tbl[r].chg);
        end
    endtask

    task automatic run_random(int n_ev);
        int m_credit, m_rej, ev, v, p, idx;
        int m_vend[NP];
        int m_chg[3];
        logic [3:0] s;
        m_credit = int'(bus.credit);
        m_rej = 0;
        for (int i = 0; i < NP; i++) m_vend[i] = 0;
        for (int k = 0; k < 3; k++) m_chg[k] = 0;
        clear_counts();
        for (int e = 0; e < n_ev; e++) begin
            ev = $urandom_range(0, 5);
            if (ev <= 2) begin
                v = coin_value(ev);
                if (m_credit + v <= MAXC) m_credit += v;
                else m_rej++;
                press_coin(ev);
            end else if (ev == 3) begin
                if (m_credit > 0) begin
                    while (m_credit > 0) begin
                        if (m_credit >= 25)      begin m_chg[2]++; m_credit -= 25; end
                        else if (m_credit >= 10) begin m_chg[1]++; m_credit -= 10; end
                        else if (m_credit >= 5)  begin m_chg[0]++; m_credit -= 5;  end
                        else m_credit = 0;
                    end
                end
                press(3'b000, 1'b1);
            end else begin
                s = 4'($urandom_range(0, 15));
                bus.sel = s;
                repeat (4) @(negedge clk);
            end
            p = model_price(bus.sel);
            if (m_credit > 0 && p != 0 && m_credit >= p) begin
                idx = 0;
                for (int i = NP-1; i >= 0; i--) if (bus.sel[i]) idx = i;
                m_vend[idx]++;
                m_credit -= p;
                while (m_credit > 0) begin
                    if (m_credit >= 25)      begin m_chg[2]++; m_credit -= 25; end
                    else if (m_credit >= 10) begin m_chg[1]++; m_credit -= 10; end
                    else if (m_credit >= 5)  begin m_chg[0]++; m_credit -= 5;  end
                    else m_credit = 0;
                end
            end
            wait_idle();
            check($sformatf("rnd%0d_credit", e), int'(bus.credit), m_credit);
        end
        check("rnd_reject", rej_cnt, m_rej);
        for (int i = 0; i < NP; i++) check($sformatf("rnd_vend%0d", i), vend_cnt[i], m_vend[i]);
        for (int k = 0; k < 3; k++) check($sformatf("rnd_chg%0d", k), chg_cnt[k], m_chg[k]);
    endtask

    initial begin
        bus.coin = 3'b000;
        bus.cancel = 1'b0;
        bus.sel = '0;
        mprice = '{15, 20, 0, 30};
        load_prices();
        clear_counts();

        repeat (3) @(negedge clk);
        #1;
        check("rst_credit", int'(bus.credit), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_vend", int'(bus.vend), 0);
        check("rst_chg", int'(bus.chg_coin), 0);
        check("rst_reject", int'(bus.reject), 0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        //               act  sel      credit rej vmask    chg
        tbl.push_back('{1, 4'b0010, 10, 0, 4'b0000, 0});
        tbl.push_back('{1, 4'b0010,  0, 0, 4'b0010, 0});
        tbl.push_back('{2, 4'b0000, 25, 0, 4'b0000, 0});
        tbl.push_back('{0, 4'b0000, 30, 0, 4'b0000, 0});
        tbl.push_back('{1, 4'b0000, 30, 1, 4'b0000, 0});
        tbl.push_back('{3, 4'b0000,  0, 0, 4'b0000, 30});
        tbl.push_back('{1, 4'b0000, 10, 0, 4'b0000, 0});
        tbl.push_back('{0, 4'b0000, 15, 0, 4'b0000, 0});
        tbl.push_back('{3, 4'b0000,  0, 0, 4'b0000, 15});
        tbl.push_back('{3, 4'b0000,  0, 0, 4'b0000, 0});
        tbl.push_back('{0, 4'b0100,  5, 0, 4'b0000, 0});
        tbl.push_back('{2, 4'b0100, 30, 0, 4'b0000, 0});
        tbl.push_back('{2, 4'b0100, 30, 1, 4'b0000, 0});
        tbl.push_back('{0, 4'b1000,  5, 0, 4'b1000, 0});
        tbl.push_back('{3, 4'b0000,  0, 0, 4'b0000, 5});
        tbl.push_back('{2, 4'b0000, 25, 0, 4'b0000, 0});
        tbl.push_back('{1, 4'b0000, 35, 0, 4'b0000, 0});
        tbl.push_back('{4, 4'b0001,  0, 0, 4'b0001, 20});
        tbl.push_back('{2, 4'b0001,  0, 0, 4'b0001, 10});
        run_table();

        // Purchase at 35, change 20 as two COIN1 on consecutive ticks
        bus.sel = '0;
        press_coin(2);
        press_coin(1);
        clear_counts();
        bus.sel = 4'b0001;
        repeat (4) @(negedge clk);
        wait_idle();
        check("seqA_vend0", vend_cnt[0], 1);
        check("seqA_nchg", chg_log.size(), 2);
        if (chg_log.size() == 2) begin
            check("seqA_first", chg_log[0], 1);
            check("seqA_second", chg_log[1], 1);
            check("seqA_gap", chg_cyc[1] - chg_cyc[0], 4);
        end

        // Cancel at 15: COIN1 then COIN0, busy held while change pending
        bus.sel = '0;
        press_coin(1);
        press_coin(0);
        clear_counts();
        tick_en = 1'b0;
        press(3'b000, 1'b1);
        check("seqB_busy", int'(bus.busy), 1);
        check("seqB_hold", int'(bus.credit), 15);
        tick_en = 1'b1;
        wait_idle();
        check("seqB_nchg", chg_log.size(), 2);
        if (chg_log.size() == 2) begin
            check("seqB_first", chg_log[0], 1);
            check("seqB_second", chg_log[1], 0);
        end
        check("seqB_busy_end", int'(bus.busy), 0);

        // Simultaneous COIN0 and COIN2 edges
        clear_counts();
        press(3'b101, 1'b0);
        wait_idle();
        check("seqC_credit", int'(bus.credit), 5);
        check("seqC_reject", rej_cnt, 0);
        press(3'b000, 1'b1);
        wait_idle();

        // Coin during CHANGE is rejected and does not alter the refund
        press_coin(2);
        press_coin(1);
        clear_counts();
        tick_en = 1'b0;
        press(3'b000, 1'b1);
        press_coin(0);
        check("seqD_reject", rej_cnt, 1);
        check("seqD_credit", int'(bus.credit), 35);
        tick_en = 1'b1;
        wait_idle();
        check("seqD_refund", chg_value(), 35);

        // Reset mid-change with 10 remaining
        press_coin(2);
        press_coin(1);
        tick_en = 1'b0;
        press(3'b000, 1'b1);
        tick_en = 1'b1;
        for (int n = 0; n < 100 && bus.credit != 8'd10; n++) @(negedge clk);
        check("seqE_reach10", int'(bus.credit), 10);
        clr_n = 1'b0;
        #1;
        check("seqE_credit", int'(bus.credit), 0);
        check("seqE_busy", int'(bus.busy), 0);
        check("seqE_chg", int'(bus.chg_coin), 0);
        check("seqE_vend", int'(bus.vend), 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        clear_counts();
        repeat (20) @(negedge clk);
        check("seqE_nochg", chg_value(), 0);
        check("seqE_idle", int'(bus.credit), 0);

        // Random run with new prices
        for (int i = 0; i < NP; i++)
            mprice[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
        bus.sel = '0;
        load_prices();
        repeat (2) @(negedge clk);
        run_random(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
